// File: rtl/hilo_div_unit.sv
// HI/LO register unit: captures ALU products, MTHI/MTLO moves, and runs
// DIV/DIVU as a 32-iteration restoring divide with a busy stall output.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_WRITE_ALU = 3'b001;
  localparam logic [2:0] OP_DIV       = 3'b010;
  localparam logic [2:0] OP_DIVU      = 3'b011;
  localparam logic [2:0] OP_MTHI      = 3'b100;
  localparam logic [2:0] OP_MTLO      = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  logic             accept_s;
  logic             is_signed_s;
  logic             rs_neg_s;
  logic             rt_neg_s;
  logic [WIDTH-1:0] rs_mag_s;
  logic [WIDTH-1:0] rt_mag_s;
  logic [WIDTH:0]   shifted_s;
  logic             ge_s;

  always_comb begin
    accept_s    = op_valid & ~busy_q;
    is_signed_s = (op == OP_DIV);
    rs_neg_s    = is_signed_s & rs_val[WIDTH-1];
    rt_neg_s    = is_signed_s & rt_val[WIDTH-1];
    rs_mag_s    = rs_neg_s ? (32'd0 - rs_val) : rs_val;
    rt_mag_s    = rt_neg_s ? (32'd0 - rt_val) : rt_val;
    // Trial compare is done one bit wider so the shifted remainder never wraps.
    shifted_s   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    ge_s        = ({rem_q, quo_q[WIDTH-1]} >= {2'b00, dvs_q});

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (op)
            OP_WRITE_ALU: begin
              hi_d = alu_hi;
              lo_d = alu_lo;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_DIV, OP_DIVU: begin
              if (rt_val == 32'd0) begin
                dbz_d = 1'b1;
              end else begin
                state_d = S_DIV;
                cnt_d   = 5'd0;
                rem_d   = 33'd0;
                dvs_d   = rt_mag_s;
                quo_d   = rs_mag_s;
                q_neg_d = rs_neg_s ^ rt_neg_s;
                r_neg_d = rs_neg_s;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        if (ge_s) begin
          rem_d = shifted_s - {1'b0, dvs_q};
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_s;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIN;
        end else begin
          state_d = S_DIV;
        end
      end
      S_FIN: begin
        lo_d    = q_neg_q ? (32'd0 - quo_q) : quo_q;
        hi_d    = r_neg_q ? (32'd0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All state and registered outputs; reset discards any in-flight divide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 33'd0;
      dvs_q   <= 32'd0;
      quo_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed self-checking bench for hilo_div_unit; expected HI/LO pairs are
// queued when a request is driven and compared when the result should appear.
module tb_hilo_div_unit;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_WRITE_ALU = 3'b001;
  localparam logic [2:0] OP_DIV       = 3'b010;
  localparam logic [2:0] OP_DIVU      = 3'b011;
  localparam logic [2:0] OP_MTHI      = 3'b100;
  localparam logic [2:0] OP_MTLO      = 3'b101;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] alu_hi, alu_lo, rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;
  logic        div_by_zero;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .alu_hi(alu_hi), .alu_lo(alu_lo), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.hi = h;
    e.lo = l;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, hi, e.hi);
      check({tag, "_lo"}, lo, e.lo);
    end
  endtask

  // Issue a divide, count busy cycles (bounded), then check the result.
  // hold_req leaves a WRITE_ALU request pending on the bus throughout.
  task automatic run_div(input string tag, input logic [2:0] dop,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic hold_req);
    int n;
    logic [31:0] pre_hi, pre_lo;
    pre_hi = hi;
    pre_lo = lo;
    op_valid = 1'b1;
    op = dop;
    rs_val = a;
    rt_val = b;
    push_exp(exp_hi, exp_lo);
    tick();
    op = OP_WRITE_ALU;
    op_valid = hold_req;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (hi !== pre_hi || lo !== pre_lo) begin
        check({tag, "_hold_hi"}, hi, pre_hi);
        check({tag, "_hold_lo"}, lo, pre_lo);
      end
      tick();
      n++;
    end
    check({tag, "_busy_cycles"}, n, 32'd33);
    check_sb(tag);
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 1'b1;
    op = OP_MTHI;
    rs_val = 32'h1234_5678;
    rt_val = 32'd0;
    alu_hi = 32'd0;
    alu_lo = 32'd0;

    tick();
    tick();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

    reset = 1'b0;
    push_exp(32'h1234_5678, 32'd0);
    tick();
    check_sb("mthi");

    op = OP_WRITE_ALU;
    alu_hi = 32'h0000_0001;
    alu_lo = 32'hFFFF_FFFE;
    push_exp(32'h0000_0001, 32'hFFFF_FFFE);
    tick();
    check_sb("write_alu");

    op = OP_MTLO;
    rs_val = 32'hA5A5_A5A5;
    push_exp(32'h0000_0001, 32'hA5A5_A5A5);
    tick();
    check_sb("mtlo");

    op = OP_NOP;
    rs_val = 32'hDEAD_0000;
    push_exp(32'h0000_0001, 32'hA5A5_A5A5);
    tick();
    check_sb("nop");

    alu_hi = 32'h0000_DEAD;
    alu_lo = 32'h0000_BEEF;
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    push_exp(32'h0000_DEAD, 32'h0000_BEEF);
    tick();
    check_sb("held_write_alu");
    op_valid = 1'b0;
    tick();

    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 1'b0);

    op_valid = 1'b1;
    op = OP_MTHI;
    rs_val = 32'h11;
    tick();
    op = OP_MTLO;
    rs_val = 32'h22;
    tick();
    op = OP_DIV;
    rs_val = 32'd5;
    rt_val = 32'd0;
    tick();
    op_valid = 1'b0;
    check("dbz_pulse", {31'd0, div_by_zero}, 32'd1);
    check("dbz_busy0", {31'd0, busy}, 32'd0);
    push_exp(32'h11, 32'h22);
    tick();
    check("dbz_drop", {31'd0, div_by_zero}, 32'd0);
    check("dbz_busy1", {31'd0, busy}, 32'd0);
    check_sb("dbz_regs");

    op_valid = 1'b1;
    op = OP_DIVU;
    rs_val = 32'hFFFF_FFFF;
    rt_val = 32'd3;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);

    run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
# hilo_div_unit

HI/LO register unit with an integrated iterative divider. It sits directly downstream of the ALU and captures the 64-bit `ALU_Hi`/`ALU_Lo` product for MULT/MULTU. It also executes MTHI/MTLO, and runs DIV/DIVU as a 32-iteration restoring divide. While a divide is in flight it raises `busy`, which the pipeline uses as a stall.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  request strobe, qualified by `~busy`.
- `op`  in  3  request code:
  - 3'b001: WRITE_ALU
  - 3'b010: DIV (signed)
  - 3'b011: DIVU
  - 3'b100: MTHI
  - 3'b101: MTLO
  - every other code is a NOP.
- `alu_hi`  in  32  ALU `ALU_Hi` output, used by WRITE_ALU.
- `alu_lo`  in  32  ALU `ALU_Lo` output, used by WRITE_ALU.
- `rs_val`  in  32  dividend, and source for MTHI/MTLO.
- `rt_val`  in  32  divisor.
- `busy`  out  1  divide in progress; new requests are not accepted.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `div_by_zero`  out  1  one-cycle pulse when a divide is requested with `rt_val == 0`.

## Operation
- Accept condition: `op_valid & ~busy` at a rising edge. Requests presented while `busy` is high are ignored, and the requester holds `op_valid` and operands until `busy` falls.
- WRITE_ALU: on the accepting edge, `hi <= alu_hi`, `lo <= alu_lo`.
- MTHI: `hi <= rs_val`; `lo` is unchanged.
- MTLO: `lo <= rs_val`; `hi` is unchanged.
- NOP codes: no effect.
- DIV/DIVU with `rt_val == 0`:
  - no division is started and `hi`/`lo` are unchanged.
  - `div_by_zero` is high for exactly the cycle after the accepting edge.
  - `busy` stays low.
- DIV/DIVU with `rt_val != 0`:
  - Operands are latched. For DIV, magnitudes are taken and the signs recorded: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Restoring divide, one quotient bit per cycle, MSB first. Uses a 33-bit partial remainder, the 32-bit divisor magnitude and a 32-bit quotient shift register.
- State machine:
  - IDLE: on an accepted nonzero divide → DIV, with iteration counter = 0.
  - DIV: one iteration per cycle; counter increments; after iteration 31 → FIN.
  - FIN: applies two's-complement negation where required, writes `lo <= quotient`, `hi <= remainder`, → IDLE.
- Signed results:
  - quotient truncates toward zero.
  - remainder carries the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields `lo = 0x80000000`, `hi = 0`.
- Reset, at any time including mid-divide: state = IDLE, `hi = 0`, `lo = 0`, `busy = 0`, `div_by_zero = 0`, counter = 0; any in-flight divide is discarded.

## Timing
- Reset values of every output are 0.
- WRITE_ALU, MTHI and MTLO have 1-cycle latency: the new value is visible on `hi`/`lo` immediately after the accepting edge.
- Divide latency:
  - `busy` rises after the accepting edge (edge 0).
  - 32 DIV cycles run, then the FIN edge (edge 33) updates `hi`/`lo` and drops `busy` together.
  - `busy` is therefore high for exactly 33 cycles.
- A new request may be accepted on the first edge at which `busy` is sampled low, i.e. the edge following the FIN edge.
- `hi`/`lo` hold their pre-divide values throughout the divide; there is no partial update.
- `alu_hi`/`alu_lo` are combinational from the ALU and are sampled only on the accepting edge.

## Test plan
- Reset with stimulus active: assert `reset` for 2 cycles while driving `op_valid = 1`, `op = MTHI`, `rs_val = 0x12345678` → `hi = lo = 0`, `busy = 0`, `div_by_zero = 0`; after release, one accepted MTHI gives `hi = 0x12345678`.
- WRITE_ALU then MTLO: `alu_hi = 0x00000001`, `alu_lo = 0xFFFFFFFE` → next cycle `hi = 0x1`, `lo = 0xFFFFFFFE`. Then MTLO with `rs_val = 0xA5A5A5A5` → `lo = 0xA5A5A5A5`, `hi` still 0x1.
- DIVU 100/7 → `busy` high 33 cycles, then `lo = 14`, `hi = 2`. A WRITE_ALU request held during `busy` is applied only on the edge after `busy` falls.
- Signed DIV cases:
  - -7/2 (0xFFFFFFF9 / 2) → `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`.
  - 7/-2 → `lo = 0xFFFFFFFD`, `hi = 1`.
  - 0x80000000 / 0xFFFFFFFF → `lo = 0x80000000`, `hi = 0`.
- DIV by zero with `hi = 0x11`, `lo = 0x22` → `div_by_zero` high for one cycle, `busy` never rises, `hi`/`lo` unchanged.
- Reset at DIV cycle 15 of DIVU 0xFFFFFFFF / 3 → `busy = 0` and `hi = lo = 0` after the reset edge. A following DIVU 9/3 completes normally with `lo = 3`, `hi = 0` after 33 busy cycles.
